// File: rtl/osc_trig_acq_if.sv
`default_nettype none
// ============================================================================
// Module      : osc_trig_acq_if
// Description : Bus bundle between the ADC capture registers, the trigger /
//               acquisition sequencer and the sample RAM write port.
// Revision    : 1.0  initial release
// ============================================================================
interface osc_trig_acq_if #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int RAM_W = 10
);
    logic [NCH*DW-1:0] data_in;
    logic              arm;
    logic              rd_done;
    logic [1:0]        mode;
    logic [NCH-1:0]    trig_en;
    logic              trig_rising;
    logic [DW-1:0]     thresh_lo;
    logic [DW-1:0]     thresh_hi;
    logic [RAM_W-1:0]  tot;
    logic              ext_trig;
    logic              trig_in;
    logic [RAM_W-1:0]  triggerpoint;
    logic [RAM_W-1:0]  nsmp;
    logic [4:0]        downsample;
    logic              highres;

    logic              wr_en;
    logic [RAM_W-1:0]  wraddress;
    logic [NCH*DW-1:0] wr_data;
    logic [RAM_W-1:0]  trig_addr;
    logic              data_ready;
    logic              acquiring;
    logic              trig_out;

    // Control/sample source side
    modport master (
        output data_in, arm, rd_done, mode, trig_en, trig_rising, thresh_lo,
               thresh_hi, tot, ext_trig, trig_in, triggerpoint, nsmp,
               downsample, highres,
        input  wr_en, wraddress, wr_data, trig_addr, data_ready, acquiring,
               trig_out
    );

    // Sequencer side
    modport slave (
        input  data_in, arm, rd_done, mode, trig_en, trig_rising, thresh_lo,
               thresh_hi, tot, ext_trig, trig_in, triggerpoint, nsmp,
               downsample, highres,
        output wr_en, wraddress, wr_data, trig_addr, data_ready, acquiring,
               trig_out
    );
endinterface
`default_nettype wire

// File: rtl/osc_trig_acq.sv
`default_nettype none
// ============================================================================
// Module      : osc_trig_acq
// Description : Multi-channel window trigger with time-over-threshold
//               qualification, NORMAL/AUTO/FORCE modes and pre/post-trigger
//               capture sequencing into a circular sample RAM.
// Options     : OSC_HIGHRES_EN - enables per-channel averaging (highres)
// Revision    : 1.0  initial release
// ============================================================================
module osc_trig_acq #(
    parameter int NCH        = 4,
    parameter int DW         = 8,
    parameter int RAM_W      = 10,
    parameter int AUTO_TICKS = 25000000,
    parameter int MAXHR      = 5
) (
    input logic              clk,
    input logic              rst,
    osc_trig_acq_if.slave    bus
);
    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_preacq  = 3'd1;
    localparam logic [2:0]  c_st_waiting = 3'd2;
    localparam logic [2:0]  c_st_postacq = 3'd3;
    localparam logic [2:0]  c_st_done    = 3'd4;
    localparam logic [31:0] c_auto_ticks = 32'(AUTO_TICKS);
    localparam logic [RAM_W:0] c_cnt_one = (RAM_W+1)'(1);

    logic [NCH*DW-1:0] r_d1;
    logic [NCH-1:0]    r_w1, r_w2, w_win, w_edge, w_cond, w_fire;
    logic [31:0]       r_ds_cnt, r_wait_cnt, w_ds_max;
    logic              w_tick, w_store, w_selftrig, w_trigger, r_trig_out;
    logic [2:0]        r_state, w_state_nxt;
    logic [RAM_W-1:0]  r_sc, w_sc_nxt, w_sc_inc, w_post_len, w_first;
    logic [RAM_W-1:0]  r_wraddr, r_trig_addr, w_trig_addr_nxt;
    logic              r_acq, w_acq_nxt, r_ready, w_ready_nxt;
    logic [NCH*DW-1:0] w_wr_data;

    // Input sample and window-state pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1 <= '0;
            r_w1 <= '0;
            r_w2 <= '0;
        end else begin
            r_d1 <= bus.data_in;
            r_w1 <= w_win;
            r_w2 <= r_w1;
        end
    end

    // Store tick: one sample in every 2^downsample
    assign w_ds_max = (32'd1 << bus.downsample) - 32'd1;
    assign w_tick   = (bus.downsample == 5'd0) || (r_ds_cnt == w_ds_max);
    assign w_store  = w_tick & r_acq;

    // Downsample phase counter, free-running in every state
    always_ff @(posedge clk) begin
        if (rst || w_tick) r_ds_cnt <= '0;
        else               r_ds_cnt <= r_ds_cnt + 32'd1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0]  w_smp;
        logic [RAM_W:0] r_cnt;
        logic           r_fire_c;

        assign w_smp     = r_d1[c*DW +: DW];
        assign w_win[c]  = (w_smp >= bus.thresh_lo) && (w_smp <= bus.thresh_hi);
        assign w_edge[c] = bus.trig_rising ? (r_w1[c] & ~r_w2[c]) : (~r_w1[c] & r_w2[c]);
        assign w_cond[c] = bus.trig_rising ? r_w1[c] : ~r_w1[c];
        assign w_fire[c] = r_fire_c;

        // Edge detect with optional time-over-threshold qualification
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt    <= '0;
                r_fire_c <= 1'b0;
            end else if (bus.tot == '0) begin
                r_cnt    <= '0;
                r_fire_c <= w_edge[c];
            end else begin
                r_fire_c <= 1'b0;
                if (r_cnt > {1'b0, bus.tot}) begin
                    r_fire_c <= 1'b1;
                    r_cnt    <= '0;
                end else if (w_edge[c]) begin
                    r_cnt <= c_cnt_one;
                end else if (w_tick && (r_cnt != '0)) begin
                    if (!w_cond[c])      r_cnt <= '0;
                    else if (r_cnt != '1) r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

    assign w_selftrig = (|(bus.trig_en & w_fire)) | bus.ext_trig;
    assign w_trigger  = w_selftrig | bus.trig_in
                      | ((bus.mode == 2'd1) && (r_wait_cnt == c_auto_ticks))
                      | ((bus.mode == 2'd2) && (r_wait_cnt == 32'd0));

    // Cycles spent in WAITING; holds once the AUTO limit is reached
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_st_waiting)) r_wait_cnt <= '0;
        else if (r_wait_cnt != c_auto_ticks)  r_wait_cnt <= r_wait_cnt + 32'd1;
    end

    assign w_sc_inc   = r_sc + 1'b1;
    assign w_post_len = bus.nsmp - bus.triggerpoint;
    assign w_first    = {{(RAM_W-1){1'b0}}, w_store};

    // Acquisition sequencer: next state and flags
    always_comb begin
        w_state_nxt     = r_state;
        w_sc_nxt        = r_sc;
        w_acq_nxt       = r_acq;
        w_ready_nxt     = r_ready;
        w_trig_addr_nxt = r_trig_addr;
        case (r_state)
            c_st_idle: begin
                if (bus.arm) begin
                    w_state_nxt = c_st_preacq;
                    w_sc_nxt    = '0;
                    w_acq_nxt   = 1'b1;
                end
            end
            c_st_preacq: begin
                if (w_store) w_sc_nxt = w_sc_inc;
                if ((bus.triggerpoint == '0) || (w_store && (w_sc_inc == bus.triggerpoint))) begin
                    w_state_nxt = c_st_waiting;
                    w_sc_nxt    = '0;
                end
            end
            c_st_waiting: begin
                if (w_trigger) begin
                    // The store made in the trigger cycle is the first post-trigger sample
                    w_trig_addr_nxt = r_wraddr;
                    w_sc_nxt        = w_first;
                    if ((w_post_len == '0) || (w_first == w_post_len)) begin
                        w_state_nxt = c_st_done;
                        w_acq_nxt   = 1'b0;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_st_postacq;
                    end
                end
            end
            c_st_postacq: begin
                if (w_store) begin
                    w_sc_nxt = w_sc_inc;
                    if (w_sc_inc == w_post_len) begin
                        w_state_nxt = c_st_done;
                        w_acq_nxt   = 1'b0;
                        w_ready_nxt = 1'b1;
                    end
                end
            end
            c_st_done: begin
                if (bus.rd_done) begin
                    w_ready_nxt = 1'b0;
                    if (bus.arm) begin
                        w_state_nxt = c_st_preacq;
                        w_sc_nxt    = '0;
                        w_acq_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_acq_nxt   = 1'b0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer registers, write pointer and neighbour trigger output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_sc        <= '0;
            r_acq       <= 1'b0;
            r_ready     <= 1'b0;
            r_trig_addr <= '0;
            r_wraddr    <= '0;
            r_trig_out  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc        <= w_sc_nxt;
            r_acq       <= w_acq_nxt;
            r_ready     <= w_ready_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            r_trig_out  <= w_selftrig;
            if (w_store) r_wraddr <= r_wraddr + 1'b1;
        end
    end

`ifdef OSC_HIGHRES_EN
    localparam int c_aw = DW + MAXHR;
    logic [MAXHR-1:0] r_hr_cnt;
    logic             w_hr_flush, w_hr_on;
    logic [4:0]       w_shift;

    assign w_hr_flush = (r_hr_cnt == '1);
    assign w_hr_on    = bus.highres && (bus.downsample != 5'd0);
    assign w_shift    = (bus.downsample > 5'(MAXHR)) ? 5'(MAXHR) : bus.downsample;

    // Accumulated-sample counter bounding the averaging depth
    always_ff @(posedge clk) begin
        if (rst || w_tick || w_hr_flush) r_hr_cnt <= '0;
        else                             r_hr_cnt <= r_hr_cnt + 1'b1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_hr
        logic [c_aw-1:0] r_acc, w_sum;
        logic [DW-1:0]   w_avg;
        assign w_sum = r_acc + c_aw'(r_d1[c*DW +: DW]);
        assign w_avg = DW'(w_sum >> w_shift);
        assign w_wr_data[c*DW +: DW] = w_hr_on ? w_avg : r_d1[c*DW +: DW];

        // Running sum, restarted at every store tick or depth overflow
        always_ff @(posedge clk) begin
            if (rst || w_tick || w_hr_flush) r_acc <= '0;
            else                             r_acc <= w_sum;
        end
    end
`else
    localparam int c_unused_maxhr = MAXHR;
    logic w_unused_hr;
    assign w_unused_hr = bus.highres;
    assign w_wr_data   = r_d1;
`endif

    assign bus.wr_en      = w_store;
    assign bus.wraddress  = r_wraddr;
    assign bus.wr_data    = w_wr_data;
    assign bus.trig_addr  = r_trig_addr;
    assign bus.data_ready = r_ready;
    assign bus.acquiring  = r_acq;
    assign bus.trig_out   = r_trig_out;
endmodule
`default_nettype wire

// File: tb/tb_osc_trig_acq.sv
`default_nettype none
// ============================================================================
// Module      : tb_osc_trig_acq
// Description : Directed self-checking bench for osc_trig_acq.
// Revision    : 1.0  initial release
// ============================================================================
module tb_osc_trig_acq;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   wr_cnt   = 0;
    int   base;
    logic any;
    logic exp_we;

    osc_trig_acq_if #(.NCH(4), .DW(8), .RAM_W(10)) bus ();

    osc_trig_acq #(
        .NCH(4), .DW(8), .RAM_W(10), .AUTO_TICKS(20), .MAXHR(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count RAM write strobes
    always @(negedge clk) if (bus.wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.data_in = 32'd50;  bus.arm = 1'b0;  bus.rd_done = 1'b0;
        bus.mode = 2'd0;  bus.trig_en = 4'b0001;  bus.trig_rising = 1'b1;
        bus.thresh_lo = 8'd100;  bus.thresh_hi = 8'd255;  bus.tot = 10'd0;
        bus.ext_trig = 1'b0;  bus.trig_in = 1'b0;  bus.triggerpoint = 10'd4;
        bus.nsmp = 10'd16;  bus.downsample = 5'd0;  bus.highres = 1'b0;
        repeat (3) step();
        chk("rst_wr_en",  32'(bus.wr_en), 32'd0);
        chk("rst_waddr",  32'(bus.wraddress), 32'd0);
        chk("rst_wdata",  bus.wr_data, 32'd0);
        chk("rst_acq",    32'(bus.acquiring), 32'd0);
        chk("rst_ready",  32'(bus.data_ready), 32'd0);
        chk("rst_tout",   32'(bus.trig_out), 32'd0);
        rst = 1'b0;
        step(); step();

        // NORMAL record: tp=4, nsmp=16, crossing on cycle A+2 -> trigger at A+5
        bus.arm = 1'b1;
        step();                                    // A+1
        bus.arm = 1'b0;
        base = wr_cnt;
        chk("n_acq",   32'(bus.acquiring), 32'd1);
        chk("n_we0",   32'(bus.wr_en), 32'd1);
        chk("n_addr0", 32'(bus.wraddress), 32'd0);
        step();                                    // A+2
        bus.data_in = 32'd150;
        repeat (3) step();                         // A+5
        chk("n_addr_trig", 32'(bus.wraddress), 32'd4);
        chk("n_tout_pre",  32'(bus.trig_out), 32'd0);
        step();                                    // A+6
        chk("n_tout",     32'(bus.trig_out), 32'd1);
        chk("n_trigaddr", 32'(bus.trig_addr), 32'd4);
        repeat (10) step();                        // A+16
        chk("n_last_we",    32'(bus.wr_en), 32'd1);
        chk("n_ready_early", 32'(bus.data_ready), 32'd0);
        step();                                    // A+17
        chk("n_ready",  32'(bus.data_ready), 32'd1);
        chk("n_acq_end", 32'(bus.acquiring), 32'd0);
        chk("n_addr_end", 32'(bus.wraddress), 32'd16);
        chk("n_pulses", 32'(wr_cnt - base), 32'd16);

        // TOT=5 qualification
        bus.data_in = 32'd50;  bus.rd_done = 1'b1;  bus.tot = 10'd5;
        step();
        bus.rd_done = 1'b0;
        chk("rd_release", 32'(bus.data_ready), 32'd0);
        repeat (4) step();
        bus.data_in = 32'd150;                     // 4 in-window samples
        repeat (4) step();
        bus.data_in = 32'd50;
        any = 1'b0;
        repeat (12) begin
            step();
            any = any | bus.trig_out;
        end
        chk("tot_short", 32'(any), 32'd0);
        bus.data_in = 32'd150;                     // 7 in-window samples, cycle k
        repeat (7) step();
        bus.data_in = 32'd50;
        repeat (2) step();                         // k+9
        chk("tot_pre",  32'(bus.trig_out), 32'd0);
        step();                                    // k+10
        chk("tot_fire", 32'(bus.trig_out), 32'd1);
        step();
        chk("tot_post", 32'(bus.trig_out), 32'd0);

        // AUTO record: tp=2 -> WAITING at A+3, auto trigger at A+23
        bus.tot = 10'd0;  bus.trig_en = 4'b0000;  bus.mode = 2'd1;
        bus.triggerpoint = 10'd2;  bus.nsmp = 10'd6;  bus.arm = 1'b1;
        step();                                    // A+1
        bus.arm = 1'b0;
        chk("a_addr0", 32'(bus.wraddress), 32'd16);
        repeat (22) step();                        // A+23
        chk("a_addr_trig", 32'(bus.wraddress), 32'd38);
        chk("a_trigaddr_old", 32'(bus.trig_addr), 32'd4);
        step();                                    // A+24
        chk("a_trigaddr", 32'(bus.trig_addr), 32'd38);
        chk("a_acq", 32'(bus.acquiring), 32'd1);
        repeat (3) step();                         // A+27
        chk("a_ready", 32'(bus.data_ready), 32'd1);

        // arm together with rd_done in DONE, then reset during POSTACQ
        bus.rd_done = 1'b1;  bus.arm = 1'b1;  bus.mode = 2'd2;
        bus.triggerpoint = 10'd0;  bus.nsmp = 10'd8;
        step();                                    // D+1
        bus.rd_done = 1'b0;  bus.arm = 1'b0;
        chk("ra_acq",   32'(bus.acquiring), 32'd1);
        chk("ra_ready", 32'(bus.data_ready), 32'd0);
        step(); step();                            // D+3, POSTACQ
        chk("pa_acq", 32'(bus.acquiring), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_we",    32'(bus.wr_en), 32'd0);
        chk("mr_addr",  32'(bus.wraddress), 32'd0);
        chk("mr_wdata", bus.wr_data, 32'd0);
        chk("mr_taddr", 32'(bus.trig_addr), 32'd0);
        chk("mr_acq",   32'(bus.acquiring), 32'd0);
        chk("mr_ready", 32'(bus.data_ready), 32'd0);
        step();
        chk("mr_idle", 32'(bus.acquiring), 32'd0);

        // FORCE record of 1020 stores so the next record starts at 1020
        bus.nsmp = 10'd1019;  bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (bus.data_ready === 1'b1) break;
            step();
        end
        chk("long_ready", 32'(bus.data_ready), 32'd1);
        chk("long_addr",  32'(bus.wraddress), 32'd1020);

        // downsample=2 record across the address wrap
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        bus.downsample = 5'd2;  bus.triggerpoint = 10'd2;  bus.nsmp = 10'd6;
        bus.arm = 1'b1;                            // cycle X
        step();                                    // X+1
        bus.arm = 1'b0;
        for (int t = 1; t <= 24; t++) begin
            exp_we = (t >= 3) && (((t - 3) % 4) == 0);
            chk($sformatf("ds_we_%0d", t), 32'(bus.wr_en), 32'(exp_we));
            if (t == 15) chk("ds_addr1023", 32'(bus.wraddress), 32'd1023);
            if (t == 19) chk("ds_addr0",    32'(bus.wraddress), 32'd0);
            if (t < 24) step();
        end
        chk("ds_ready",    32'(bus.data_ready), 32'd1);
        chk("ds_trigaddr", 32'(bus.trig_addr), 32'd1022);
        chk("ds_addr_end", 32'(bus.wraddress), 32'd2);

        // highres averaging over one downsample window (ticks at X+27, X+31)
        bus.rd_done = 1'b1;  bus.highres = 1'b1;  bus.mode = 2'd0;
        bus.triggerpoint = 10'd0;  bus.nsmp = 10'd8;
        step();                                    // X+25
        bus.rd_done = 1'b0;  bus.arm = 1'b1;
        step();                                    // X+26
        bus.arm = 1'b0;
        step();  bus.data_in = 32'd10;             // X+27
        step();  bus.data_in = 32'd20;
        step();  bus.data_in = 32'd30;
        step();  bus.data_in = 32'd40;             // X+30
        step();                                    // X+31
        chk("hr_we", 32'(bus.wr_en), 32'd1);
`ifdef OSC_HIGHRES_EN
        chk("hr_data", bus.wr_data, 32'd25);
`else
        chk("hr_data", bus.wr_data, 32'd40);
`endif

        rst = 1'b1;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
